// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Purpose  : Circular instruction FIFO between fetch and decode/dispatch,
//            carrying PC and branch-prediction tag with each instruction.
// Revision : 1.0  initial release
// ============================================================================
module inst_queue #(
    parameter int IQ_ADDR_WIDTH = 4,
    parameter int IQ_SIZE       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_flag,
    input  logic [31:0] IF_inst,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_BTB_PC,
    input  logic        IF_BTB_predict,
    output logic        IQ_full,
    input  logic        ID_stall,
    output logic        ID_flag,
    output logic [31:0] ID_inst,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_BTB_PC,
    output logic        ID_BTB_predict,
    input  logic        ROB_jump_flag
);

    localparam logic [IQ_ADDR_WIDTH:0] c_size     = (IQ_ADDR_WIDTH + 1)'(IQ_SIZE);
    localparam logic [IQ_ADDR_WIDTH:0] c_full_thr = (IQ_ADDR_WIDTH + 1)'(IQ_SIZE - 1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] btb_pc;
        logic        predict;
    } entry_t;

    entry_t                   r_mem [IQ_SIZE];
    logic [IQ_ADDR_WIDTH-1:0] r_head;
    logic [IQ_ADDR_WIDTH-1:0] r_tail;
    logic [IQ_ADDR_WIDTH:0]   r_count;

    logic w_push;
    logic w_pop;
    logic w_wr_en;

    // Push ignores rdy so an instruction already in flight from fetch survives a stall.
    assign w_push  = IF_flag && (r_count != c_size);
    assign w_pop   = rdy && !ID_stall && (r_count != '0);
    assign w_wr_en = w_push && !rst && !ROB_jump_flag;

    // One slot held in reserve for the push fetch has already committed to.
    assign IQ_full = (r_count >= c_full_thr);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_tail] <= {IF_inst, IF_PC, IF_BTB_PC, IF_BTB_predict};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ROB_jump_flag) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Data outputs hold their last popped value; only the valid pulse drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ID_flag        <= 1'b0;
            ID_inst        <= '0;
            ID_PC          <= '0;
            ID_BTB_PC      <= '0;
            ID_BTB_predict <= 1'b0;
        end else if (ROB_jump_flag) begin
            ID_flag <= 1'b0;
        end else if (w_pop) begin
            ID_flag <= 1'b1;
            {ID_inst, ID_PC, ID_BTB_PC, ID_BTB_predict} <= r_mem[r_head];
        end else begin
            ID_flag <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_queue
// Purpose  : Self-checking bench for inst_queue (vector table, directed
//            sequences, randomized traffic against a queue-based model).
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_queue;

    localparam int c_size = 16;

    logic        clk = 1'b0;
    logic        rst, rdy, IF_flag, IF_BTB_predict, ID_stall, ROB_jump_flag;
    logic [31:0] IF_inst, IF_PC, IF_BTB_PC;
    logic        IQ_full, ID_flag, ID_BTB_predict;
    logic [31:0] ID_inst, ID_PC, ID_BTB_PC;

    always #5 clk = ~clk;

    inst_queue #(.IQ_ADDR_WIDTH(4), .IQ_SIZE(c_size)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .IF_flag(IF_flag), .IF_inst(IF_inst), .IF_PC(IF_PC),
        .IF_BTB_PC(IF_BTB_PC), .IF_BTB_predict(IF_BTB_predict),
        .IQ_full(IQ_full), .ID_stall(ID_stall),
        .ID_flag(ID_flag), .ID_inst(ID_inst), .ID_PC(ID_PC),
        .ID_BTB_PC(ID_BTB_PC), .ID_BTB_predict(ID_BTB_predict),
        .ROB_jump_flag(ROB_jump_flag)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] btb_pc;
        logic        pred;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        if_flag;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exp_flag;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        logic        exp_full;
    } vec_t;

    ent_t q[$];
    ent_t exp_out;
    logic exp_flag;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: a plain queue; pop decisions use the occupancy seen before the edge.
    task automatic model_update();
        ent_t e;
        bit   do_pop, do_push;
        if (rst) begin
            q.delete();
            exp_flag = 1'b0;
            exp_out  = '{default: '0};
        end else if (ROB_jump_flag) begin
            q.delete();
            exp_flag = 1'b0;
        end else begin
            assert (!(IF_flag && q.size() == c_size))
                else $error("protocol violation: push into a queue holding %0d entries", q.size());
            do_pop  = rdy && !ID_stall && q.size() != 0;
            do_push = IF_flag && q.size() < c_size;
            exp_flag = do_pop;
            if (do_pop) exp_out = q.pop_front();
            if (do_push) begin
                e.inst = IF_inst; e.pc = IF_PC; e.btb_pc = IF_BTB_PC; e.pred = IF_BTB_predict;
                q.push_back(e);
            end
        end
    endtask

    task automatic compare_all();
        check("model_ID_flag",  32'(ID_flag),        32'(exp_flag));
        check("model_ID_inst",  ID_inst,             exp_out.inst);
        check("model_ID_PC",    ID_PC,               exp_out.pc);
        check("model_BTB_PC",   ID_BTB_PC,           exp_out.btb_pc);
        check("model_predict",  32'(ID_BTB_predict), 32'(exp_out.pred));
        check("model_IQ_full",  32'(IQ_full),        32'(q.size() >= c_size - 1));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic idle();
        IF_flag = 1'b0; ROB_jump_flag = 1'b0; rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] btb, input logic pred);
        IF_flag = 1'b1; IF_inst = inst; IF_PC = pc; IF_BTB_PC = btb; IF_BTB_predict = pred;
    endtask

    vec_t tbl[8];

    initial begin
        rst = 1'b1; rdy = 1'b1; ID_stall = 1'b0; ROB_jump_flag = 1'b0;
        IF_flag = 1'b0; IF_inst = '0; IF_PC = '0; IF_BTB_PC = '0; IF_BTB_predict = 1'b0;
        exp_flag = 1'b0; exp_out = '{default: '0};

        // Reset, then three pushes on alternate cycles; pop lands one edge after each push.
        tbl[0] = '{1'b1, 1'b0, 32'h0,          32'h0, 1'b0, 32'h0,          32'h0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0013,  32'h0, 1'b0, 32'h0,          32'h0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 32'h0,          32'h0, 1'b1, 32'h0000_0013,  32'h0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h0010_0093,  32'h4, 1'b0, 32'h0000_0013,  32'h0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0,          32'h0, 1'b1, 32'h0010_0093,  32'h4, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'h0020_0113,  32'h8, 1'b0, 32'h0010_0093,  32'h4, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 32'h0,          32'h0, 1'b1, 32'h0020_0113,  32'h8, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 32'h0,          32'h0, 1'b0, 32'h0020_0113,  32'h8, 1'b0};

        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst; IF_flag = tbl[i].if_flag;
            IF_inst = tbl[i].inst; IF_PC = tbl[i].pc; IF_BTB_PC = '0; IF_BTB_predict = 1'b0;
            step();
            check($sformatf("tbl%0d_flag", i), 32'(ID_flag), 32'(tbl[i].exp_flag));
            check($sformatf("tbl%0d_inst", i), ID_inst,      tbl[i].exp_inst);
            check($sformatf("tbl%0d_pc", i),   ID_PC,        tbl[i].exp_pc);
            check($sformatf("tbl%0d_full", i), 32'(IQ_full), 32'(tbl[i].exp_full));
        end
        idle();

        // Fill under stall: full at 15, in-flight 16th accepted, drain in order.
        ID_stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(32'h1000 + 32'(i), 32'h400 + 32'(i * 4), 32'h0, 1'b0);
            step();
            if (i == 13) check("full_at_14", 32'(IQ_full), 32'd0);
            if (i == 14) check("full_at_15", 32'(IQ_full), 32'd1);
            if (i == 15) check("full_at_16", 32'(IQ_full), 32'd1);
        end
        idle();
        ID_stall = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("drain%0d_inst", k), ID_inst, 32'h1000 + 32'(k));
            if (k == 0) check("full_after_pop1", 32'(IQ_full), 32'd1);
            if (k == 1) check("full_after_pop2", 32'(IQ_full), 32'd0);
        end
        step();
        check("drain_done_flag", 32'(ID_flag), 32'd0);

        // Flush with a simultaneous push: the push is discarded.
        ID_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(32'h3000 + 32'(i), 32'h600 + 32'(i * 4), 32'h0, 1'b0);
            step();
        end
        push(32'h0000_dead, 32'h200, 32'h0, 1'b0);
        ROB_jump_flag = 1'b1;
        step();
        check("flush_full", 32'(IQ_full), 32'd0);
        check("flush_flag", 32'(ID_flag), 32'd0);
        ROB_jump_flag = 1'b0; ID_stall = 1'b0;
        push(32'h0000_0111, 32'h100, 32'h0, 1'b0);
        step();
        idle();
        step();
        check("post_flush_flag", 32'(ID_flag), 32'd1);
        check("post_flush_pc",   ID_PC,        32'h100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_flush_empty", 32'(ID_flag), 32'd0);
        end

        // Prediction fields travel with their instruction.
        push(32'h0000_0063, 32'h500, 32'h40, 1'b1);
        step();
        idle();
        step();
        check("br_btb_pc", ID_BTB_PC,           32'h40);
        check("br_pred",   32'(ID_BTB_predict), 32'd1);
        push(32'h0000_0013, 32'h504, 32'h0, 1'b0);
        step();
        idle();
        step();
        check("nb_pred", 32'(ID_BTB_predict), 32'd0);
        check("nb_pc",   ID_PC,               32'h504);

        // rdy low blocks pops but not pushes.
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) push(32'h0000_0aaa, 32'h700, 32'h0, 1'b0);
            else if (c == 2) push(32'h0000_0bbb, 32'h704, 32'h0, 1'b0);
            else idle();
            step();
            check("rdy_low_flag", 32'(ID_flag), 32'd0);
        end
        idle();
        rdy = 1'b1;
        step();
        check("rdy_pop1", ID_inst, 32'h0000_0aaa);
        check("rdy_pop1_flag", 32'(ID_flag), 32'd1);
        step();
        check("rdy_pop2", ID_inst, 32'h0000_0bbb);
        check("rdy_pop2_flag", 32'(ID_flag), 32'd1);
        step();
        check("rdy_drained", 32'(ID_flag), 32'd0);

        // Steady-state traffic long enough to wrap head and tail twice.
        for (int i = 0; i < 40; i++) begin
            push(32'h2000 + 32'(i), 32'h800 + 32'(i * 4), 32'(i), i[0]);
            ID_stall = (i % 5 == 2);
            step();
        end
        idle();
        ID_stall = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic; the model never asks for a push into a full queue.
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            rdy           = ($urandom_range(0, 9) != 0);
            ID_stall      = ($urandom_range(0, 2) == 0);
            ROB_jump_flag = ($urandom_range(0, 39) == 0);
            IF_flag       = (q.size() < c_size) && ($urandom_range(0, 1) == 1);
            IF_inst       = $urandom;
            IF_PC         = $urandom;
            IF_BTB_PC     = $urandom;
            IF_BTB_predict = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        rdy = 1'b1; ID_stall = 1'b0;
        for (int i = 0; i < 20; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
